// File: rtl/riscv_pkg.sv
// Shared core package: architectural widths and the register-file clear-FSM state.
//   XLEN       - data width of every integer register
//   REG_ADDR_W - width of a register index
//   NUM_REGS   - number of architectural integer registers (x0..x31)
package riscv_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned NUM_REGS   = 32;

  // Register-file lifecycle: CLEAR wipes x1..x31 after reset, READY serves the core.
  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } rf_state_t;

endpackage : riscv_pkg

// File: rtl/reg_file_clear_ctrl.sv
// Register-file clear sequencer: after reset, walks clr_idx from 1 to 31 (one
// register per cycle) and then parks in READY until the next reset.
// Ports:
//   clk     - rising-edge clock
//   rst     - synchronous active-high reset; restarts the sweep at index 1
//   busy    - high while the sweep runs (31 cycles after the reset edge)
//   clr_we  - zero-write strobe for regs[clr_idx]
//   clr_idx - register index being cleared this cycle
module reg_file_clear_ctrl
  import riscv_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  output logic                  busy,
  output logic                  clr_we,
  output logic [REG_ADDR_W-1:0] clr_idx
);

  localparam int unsigned LAST_IDX = NUM_REGS - 1;

  rf_state_t             state;
  rf_state_t             state_nxt;
  logic [REG_ADDR_W-1:0] idx_nxt;

  // Next-state: advance through the indices, leave CLEAR once the last one is wiped.
  always_comb begin
    state_nxt = state;
    idx_nxt   = clr_idx;
    case (state)
      CLEAR: begin
        if (clr_idx == REG_ADDR_W'(LAST_IDX)) begin
          // Hold the index at 31 so the 5-bit counter never wraps to x0.
          state_nxt = READY;
        end else begin
          idx_nxt = clr_idx + REG_ADDR_W'(1);
        end
      end
      READY: begin
        state_nxt = READY;
      end
      default: begin
        state_nxt = CLEAR;
      end
    endcase
  end

  // State, counter and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLEAR;
      clr_idx <= REG_ADDR_W'(1);
      busy    <= 1'b1;
      clr_we  <= 1'b1;
    end else begin
      state   <= state_nxt;
      clr_idx <= idx_nxt;
      busy    <= (state_nxt == CLEAR);
      clr_we  <= (state_nxt == CLEAR);
    end
  end

endmodule : reg_file_clear_ctrl

// File: rtl/reg_file.sv
// 32 x 32-bit integer register file with two combinational read ports and one
// write port. x0 is hardwired to zero. After reset the registers are cleared
// one per cycle while busy is high; reads return 0 and writes are ignored then.
// Compile option: REG_FILE_BYPASS_EN forwards a same-cycle write to a matching
// read port (write-through); without it a read returns the pre-write value.
// Ports:
//   clk, rst           - clock, synchronous active-high reset
//   rs1_addr/rs1_data  - read port 1 (ALU operand a)
//   rs2_addr/rs2_data  - read port 2 (ALU operand b)
//   rd_addr/rd_data    - write port index/data, committed when reg_write=1
//   busy               - clear sweep in progress; core must stall
module reg_file
  import riscv_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] rs1_addr,
  input  logic [REG_ADDR_W-1:0] rs2_addr,
  input  logic [REG_ADDR_W-1:0] rd_addr,
  input  logic [XLEN-1:0]       rd_data,
  input  logic                  reg_write,
  output logic [XLEN-1:0]       rs1_data,
  output logic [XLEN-1:0]       rs2_data,
  output logic                  busy
);

  logic [XLEN-1:0]       regs [NUM_REGS];
  logic                  clr_we;
  logic [REG_ADDR_W-1:0] clr_idx;
  logic                  wr_en_c;

  reg_file_clear_ctrl u_clear_ctrl (
    .clk     (clk),
    .rst     (rst),
    .busy    (busy),
    .clr_we  (clr_we),
    .clr_idx (clr_idx)
  );

  // Architectural write: only in READY and never to x0.
  assign wr_en_c = reg_write && !busy && (rd_addr != '0);

  // Storage: the clear sweep owns the write port while busy; reset suppresses all writes.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (clr_we) begin
        regs[clr_idx] <= '0;
      end else if (wr_en_c) begin
        regs[rd_addr] <= rd_data;
      end
    end
  end

  // Read port 1: zero while busy or for x0.
  always_comb begin
    rs1_data = '0;
    if (!busy && (rs1_addr != '0)) begin
      rs1_data = regs[rs1_addr];
`ifdef REG_FILE_BYPASS_EN
      if (wr_en_c && (rd_addr == rs1_addr)) begin
        rs1_data = rd_data;
      end
`endif
    end
  end

  // Read port 2: same rules as port 1.
  always_comb begin
    rs2_data = '0;
    if (!busy && (rs2_addr != '0)) begin
      rs2_data = regs[rs2_addr];
`ifdef REG_FILE_BYPASS_EN
      if (wr_en_c && (rd_addr == rs2_addr)) begin
        rs2_data = rd_data;
      end
`endif
    end
  end

endmodule : reg_file

// File: tb/tb_reg_file.sv
// Directed testbench for reg_file: reset sweep, x0, read/write, same-cycle
// hazard (both builds), mid-sweep reset and back-to-back writes.
module tb_reg_file;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic        reg_write;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        busy;

  int checks = 0;
  int passed = 0;

  reg_file dut (
    .clk       (clk),
    .rst       (rst),
    .rs1_addr  (rs1_addr),
    .rs2_addr  (rs2_addr),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .reg_write (reg_write),
    .rs1_data  (rs1_data),
    .rs2_data  (rs2_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Drive one write cycle; returns at the following negedge with reg_write low.
  task automatic do_write(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    reg_write = 1'b1;
    rd_addr   = a;
    rd_data   = d;
    @(negedge clk);
    reg_write = 1'b0;
  endtask

  // Count negedges with busy high, bounded.
  task automatic count_busy(output int n);
    n = 0;
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    int n;
    // rst is high from time 0; first edge at 5, now at negedge 10
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (busy !== 1'b1) $display("FAIL reset_busy: got %b want 1", busy); else passed++;
    rs1_addr = 5'd5; rs2_addr = 5'd31; #1;
    checks++;
    if (rs1_data !== 32'h0 || rs2_data !== 32'h0)
      $display("FAIL reset_reads_zero: got %h/%h want 0/0", rs1_data, rs2_data);
    else passed++;
    count_busy(n);
    checks++;
    if (n !== 31) $display("FAIL reset_busy_len: got %0d want 31", n); else passed++;
    for (int i = 1; i < 32; i += 10) begin
      rs1_addr = 5'(i); rs2_addr = 5'(31 - i); #1;
      checks++;
      if (rs1_data !== 32'h0 || rs2_data !== 32'h0)
        $display("FAIL ready_zero_x%0d: got %h/%h want 0/0", i, rs1_data, rs2_data);
      else passed++;
    end
  endtask

  task automatic test_reset_clear();
    int n;
    do_write(5'd5, 32'hDEADBEEF);
    rs1_addr = 5'd5; #1;
    checks++;
    if (rs1_data !== 32'hDEADBEEF) $display("FAIL x5_written: got %h want deadbeef", rs1_data);
    else passed++;
    pulse_reset();
    count_busy(n);
    checks++;
    if (n !== 31) $display("FAIL clear_busy_len: got %0d want 31", n); else passed++;
    rs1_addr = 5'd5; #1;
    checks++;
    if (rs1_data !== 32'h0) $display("FAIL x5_cleared: got %h want 0", rs1_data); else passed++;
  endtask

  task automatic test_x0();
    do_write(5'd0, 32'hFFFFFFFF);
    rs1_addr = 5'd0; rs2_addr = 5'd0; #1;
    checks++;
    if (rs1_data !== 32'h0 || rs2_data !== 32'h0)
      $display("FAIL x0_write: got %h/%h want 0/0", rs1_data, rs2_data);
    else passed++;
  endtask

  task automatic test_write_read();
    do_write(5'd7, 32'h12345678);
    rs1_addr = 5'd7; rs2_addr = 5'd7; #1;
    checks++;
    if (rs1_data !== 32'h12345678 || rs2_data !== 32'h12345678)
      $display("FAIL x7_both_ports: got %h/%h want 12345678", rs1_data, rs2_data);
    else passed++;
  endtask

  task automatic test_hazard();
    logic [31:0] exp_same;
`ifdef REG_FILE_BYPASS_EN
    exp_same = 32'h22;
`else
    exp_same = 32'h11;
`endif
    do_write(5'd3, 32'h11);
    @(negedge clk);
    reg_write = 1'b1; rd_addr = 5'd3; rd_data = 32'h22;
    rs1_addr = 5'd3; rs2_addr = 5'd7; #1;
    checks++;
    if (rs1_data !== exp_same) $display("FAIL hazard_same_cycle: got %h want %h", rs1_data, exp_same);
    else passed++;
    checks++;
    if (rs2_data !== 32'h12345678) $display("FAIL hazard_other_port: got %h want 12345678", rs2_data);
    else passed++;
    @(negedge clk);
    reg_write = 1'b0; #1;
    checks++;
    if (rs1_data !== 32'h22) $display("FAIL hazard_next_cycle: got %h want 22", rs1_data);
    else passed++;
  endtask

  task automatic test_mid_clear();
    int n;
    pulse_reset();
    for (int i = 0; i < 9; i++) @(negedge clk);
    checks++;
    if (busy !== 1'b1) $display("FAIL mid_busy_before: got %b want 1", busy); else passed++;
    // Reset at busy cycle 10 with a write attempt; keep writing through the sweep.
    rst = 1'b1; reg_write = 1'b1; rd_addr = 5'd9; rd_data = 32'h55;
    @(negedge clk);
    rst = 1'b0;
    count_busy(n);
    reg_write = 1'b0;
    checks++;
    if (n !== 31) $display("FAIL mid_busy_len: got %0d want 31", n); else passed++;
    rs1_addr = 5'd9; rs2_addr = 5'd3; #1;
    checks++;
    if (rs1_data !== 32'h0 || rs2_data !== 32'h0)
      $display("FAIL mid_writes_lost: got %h/%h want 0/0", rs1_data, rs2_data);
    else passed++;
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    reg_write = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      rd_addr = 5'(i); rd_data = 32'hA000_0000 + 32'(i);
      @(negedge clk);
    end
    reg_write = 1'b0;
    for (int i = 1; i <= 4; i += 2) begin
      rs1_addr = 5'(i); rs2_addr = 5'(i + 1); #1;
      checks++;
      if (rs1_data !== 32'hA000_0000 + 32'(i) || rs2_data !== 32'hA000_0000 + 32'(i + 1))
        $display("FAIL b2b_x%0d_x%0d: got %h/%h", i, i + 1, rs1_data, rs2_data);
      else passed++;
    end
  endtask

  initial begin
    rst = 1'b1; reg_write = 1'b0;
    rs1_addr = '0; rs2_addr = '0; rd_addr = '0; rd_data = '0;
    test_reset();
    test_reset_clear();
    test_x0();
    test_write_read();
    test_hazard();
    test_mid_clear();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule : tb_reg_file

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset: clk and rst, listed first.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous, active-high reset; starts the clear sequence.
REQ-004 rs1_addr  input  5  read-port-1 register index; drives ALU operand a.
REQ-005 rs2_addr  input  5  read-port-2 register index; drives ALU operand b.
REQ-006 rd_addr  input  5  write-port register index.
REQ-007 rd_data  input  32  write data, normally the ALU result or load data.
REQ-008 reg_write  input  1  write enable for rd_addr/rd_data.
REQ-009 rs1_data  output  32  read-port-1 data.
REQ-010 rs2_data  output  32  read-port-2 data.
REQ-011 busy  output  1  clear sequence in progress; the core SHALL stall while it is high.

Function
REQ-012 Storage SHALL be 32 x 32-bit registers; x0 SHALL always read 0, and writes to x0 SHALL be discarded.
REQ-013 Reads SHALL be combinational from rs1_addr/rs2_addr (zero-cycle latency).
REQ-014 A write SHALL commit on the rising clk edge when reg_write=1, rd_addr!=0, and the state is READY.
REQ-015 The FSM SHALL have exactly two states: CLEAR and READY; busy = (state==CLEAR).
REQ-016 CLEAR: each cycle, regs[clr_idx] <= 0 and clr_idx++, with clr_idx starting at 1.
- When clr_idx==31 is written, the next state SHALL be READY.
- Busy SHALL therefore be high for exactly 31 cycles after the reset edge.
REQ-017 While busy=1, rs1_data and rs2_data SHALL read 0, and reg_write SHALL be ignored.
REQ-018 READY SHALL be held until rst; no other transition SHALL exist.
REQ-019 Simultaneous write and read of the same register without bypass: the read SHALL return the old value; the new value is visible the next cycle.
REQ-020 If both read ports address the same register, both SHALL return identical data.
REQ-021 The 5-bit clr_idx SHALL not wrap: the transition to READY occurs at 31.

Reset
REQ-022 On any clk edge with rst=1: state <= CLEAR, clr_idx <= 1, and all writes that cycle are suppressed.
REQ-023 Reset asserted mid-clear SHALL restart the sequence at clr_idx=1 with the full 31-cycle busy window.
REQ-024 Output values after the reset edge:
- busy=1.
- rs1_data=0 and rs2_data=0 until READY.
- After READY, every register SHALL read 0 until written.

Configuration
REQ-025 Macro REG_FILE_BYPASS_EN SHALL be the only compile option.
REQ-026 With REG_FILE_BYPASS_EN defined: in READY, if reg_write=1 and rd_addr!=0 and rd_addr==rsN_addr, then rsN_data SHALL equal rd_data in the same cycle (write-through).
REQ-027 Without REG_FILE_BYPASS_EN: no forwarding; REQ-019 applies.
- Port list SHALL be identical in both builds.

Structure
REQ-028 Shared package riscv_pkg SHALL hold:
- XLEN=32, REG_ADDR_W=5, NUM_REGS=32.
- The regfile state typedef {CLEAR, READY}.
REQ-029 The FSM and clr_idx counter SHALL be a natural sub-module named reg_file_clear_ctrl.
- Outputs: busy, clr_we, clr_idx.
- Storage and read muxing SHALL stay in reg_file.

Verification
REQ-030 Reset clear: write x5=0xDEADBEEF, then pulse rst one cycle.
- busy SHALL be high exactly 31 cycles.
- After busy falls, x5 SHALL read 0x00000000.
REQ-031 x0 write: reg_write=1, rd=0, rd_data=0xFFFFFFFF, then rs1=0 -> rs1_data SHALL be 0x00000000.
REQ-032 Write/read: write x7=0x12345678.
- Next cycle, rs1=7 and rs2=7 -> both ports SHALL read 0x12345678.
REQ-033 Same-cycle hazard: x3=0x11, then write x3=0x22 while rs1=3.
- Bypass build: rs1_data=0x22 that cycle.
- Non-bypass build: rs1_data=0x11 that cycle, then 0x22 the next cycle.
REQ-034 Mid-clear reset: assert rst at busy cycle 10 -> busy SHALL remain high 31 further cycles.
- Writes during busy (x9=0x55) SHALL be lost: x9 reads 0 after READY.
